// File: rtl/glitc_conf_loader.sv
// glitc_conf_loader
// Slave-serial bitstream loader for the four GLITC FPGAs. Software writes
// 32-bit bitstream words over Wishbone; they are queued in a small FIFO and
// shifted MSB-first onto DIN. CCLK is divided from clk_i and only reaches the
// GLITCs selected by the target mask. A low INIT_B on any targeted GLITC
// (CRC error) aborts the load and latches an error flag.
//
// Ports
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   cyc_i, stb_i, we_i    Wishbone strobes
//   adr_i[4:0]            byte address, [3:2] selects CTRL/DATA/WORDCOUNT
//   dat_i / dat_o         write / read data (dat_o is 0 outside a read)
//   ack_o, rty_o, err_o   handshake; rty_o only for a DATA write into a full FIFO
//   CCLK[3:0]             per-GLITC configuration clock (registered)
//   DIN                   shared serial data
//   INIT_B[3:0], DONE[3:0] asynchronous GLITC status inputs
//   busy_o                FIFO non-empty or FSM not idle
//
// state | meaning
// IDLE  | CCLK low, waiting for a queued word, a non-zero mask and no error
// LOAD  | pop one word into the shift register
// SHIFT | clock 32 bits out, CCLK low then high for CCLK_DIV cycles each
// ERROR | INIT_B fell on a targeted GLITC; FIFO flushed, wait for clear/abort

module glitc_conf_loader #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int CCLK_DIV        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        rty_o,
  output logic        err_o,
  output logic [3:0]  CCLK,
  output logic        DIN,
  input  logic [3:0]  INIT_B,
  input  logic [3:0]  DONE,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int DIV_W = (CCLK_DIV > 1) ? $clog2(CCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CCLK_DIV - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [1:0]  state;
  logic [3:0]  mask;
  logic        error;
  logic [15:0] word_cnt;
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic        cclk_int;

  logic [3:0]  init_meta, init_sync;
  logic [3:0]  done_meta, done_sync;

  logic [31:0] fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   fifo_cnt;
  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty;

  logic bus_req, wr_ctrl, wr_data;
  logic push, pop, flush, abort, clr_err, err_det;
  logic unused_bits;

  // bus decode and handshake
  assign bus_req   = cyc_i & stb_i;
  assign wr_ctrl   = bus_req & we_i & (adr_i[3:2] == 2'b00);
  assign wr_data   = bus_req & we_i & (adr_i[3:2] == 2'b01);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  // full is judged on the registered count, so a pop in the same cycle
  // does not make room for this write
  assign rty_o  = wr_data & fifo_full;
  assign push   = wr_data & ~fifo_full;
  assign ack_o  = bus_req & ~rty_o;
  assign err_o  = 1'b0;

  assign abort   = wr_ctrl & dat_i[31];
  assign clr_err = wr_ctrl & dat_i[30];
  assign err_det = ((state == S_LOAD) | (state == S_SHIFT)) & (|(mask & ~init_sync));
  assign flush   = abort | err_det;
  assign pop     = (state == S_LOAD) & ~flush;

  assign busy_o    = ~fifo_empty | (state != S_IDLE);
  assign fifo_head = fifo_mem[rd_ptr];
  assign DIN       = shreg[31];

  assign unused_bits = &{1'b0, adr_i[4], adr_i[1:0], dat_i[29:4]};

  always_comb begin
    dat_o = '0;
    if (bus_req && !we_i) begin
      case (adr_i[3:2])
        2'b00:   dat_o = {11'd0, busy_o, error, state, 5'(fifo_cnt),
                          done_sync, init_sync, mask};
        2'b10:   dat_o = {16'd0, word_cnt};
        default: dat_o = '0;
      endcase
    end
  end

  // two-flop synchronizers for the asynchronous GLITC status pins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_meta <= '0;
      init_sync <= '0;
      done_meta <= '0;
      done_sync <= '0;
    end else begin
      init_meta <= INIT_B;
      init_sync <= init_meta;
      done_meta <= DONE;
      done_sync <= done_meta;
    end
  end

  // word storage, no reset needed: validity is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      mask     <= '0;
      error    <= 1'b0;
      word_cnt <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      cclk_int <= 1'b0;
      CCLK     <= '0;
    end else begin
      if (abort) begin
        state    <= S_IDLE;
        shreg    <= '0;
        cclk_int <= 1'b0;
        CCLK     <= '0;
      end else if (err_det) begin
        // DIN is left holding its current bit
        state    <= S_ERROR;
        error    <= 1'b1;
        cclk_int <= 1'b0;
        CCLK     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cclk_int <= 1'b0;
            CCLK     <= '0;
            // a push this cycle counts, so LOAD lands the cycle after the write
            if ((!fifo_empty || push) && (mask != 4'd0) && !error)
              state <= S_LOAD;
          end
          S_LOAD: begin
            shreg    <= fifo_head;
            bit_cnt  <= 5'd31;
            div_cnt  <= DIV_LAST;
            cclk_int <= 1'b0;
            CCLK     <= '0;
            state    <= S_SHIFT;
          end
          S_SHIFT: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else begin
              div_cnt <= DIV_LAST;
              if (!cclk_int) begin
                cclk_int <= 1'b1;
                CCLK     <= mask;
              end else begin
                // end of high phase: advance to the next bit on the falling edge
                cclk_int <= 1'b0;
                CCLK     <= '0;
                shreg    <= {shreg[30:0], 1'b0};
                if (bit_cnt == 5'd0) begin
                  word_cnt <= word_cnt + 1'b1;
                  state    <= fifo_empty ? S_IDLE : S_LOAD;
                end else begin
                  bit_cnt <= bit_cnt - 1'b1;
                end
              end
            end
          end
          default: begin
            cclk_int <= 1'b0;
            CCLK     <= '0;
          end
        endcase
      end

      if (clr_err) begin
        error    <= 1'b0;
        word_cnt <= '0;
        if (state == S_ERROR && !abort) state <= S_IDLE;
      end

      // mask is only retargeted while idle, or together with an abort
      if (wr_ctrl && (state == S_IDLE || abort)) mask <= dat_i[3:0];
    end
  end

endmodule
